digit_matcher: RTL
==================

# digit_matcher

Template-matching stage for the handwritten-digit recogniser. It consumes the per-digit bitmap ROMs (`prom_0` … `prom_9`, 16 rows × 16 bits, combinational read) through a shared row address and a template select. It scores the user-drawn 16×16 grid against each template by counting agreeing pixels. It then reports the best-matching digit and its score to the result display logic.

## Interface
Parameters:
- `N_TMPL`, default 10: number of templates scanned, indices 0..N_TMPL-1.
- `ROWS`, default 16: rows per bitmap; row width is fixed at 16.

Ports:
- `clk` in 1: system clock. One clock domain.
- `rst` in 1: reset, synchronous and active-high.
- `start` in 1: begin a match run. Sampled only in IDLE.
- `tmpl_sel` out 4: template index. Drives the external mux that selects which ROM's `Char` reaches `rom_row`.
- `rom_addr` out 4: row address to the `addr` input of every template ROM.
- `rom_row` in 16 [0:15]: selected template row. Bit 0 is the leftmost pixel. Combinational from `rom_addr`/`tmpl_sel`.
- `grid_addr` out 4: row address into the drawn-grid store.
- `grid_row` in 16 [0:15]: drawn row. Combinational from `grid_addr`.
- `busy` out 1: high from the cycle after `start` is accepted until DONE is left.
- `done` out 1: one-cycle pulse when the result is valid.
- `digit` out 4: best-matching template index.
- `score` out 9: agreeing-pixel count of the best template, range 0..256.

## Operation
- State machine: IDLE, SCAN, CMP, DONE.
- IDLE:
  - `start`=1 → SCAN.
  - On entry to SCAN: tmpl=0, row=0, acc=0, best_score=0, best_digit=0.
- SCAN, every cycle:
  - acc += popcount(~(grid_row ^ rom_row)). Per-row contribution is 0..16; acc is 9 bits and never saturates.
  - row increments each cycle. When row==ROWS-1, the row-15 contribution is included and the next state is CMP.
- CMP, with the completed acc:
  - If acc > best_score (strictly): best_score=acc, best_digit=tmpl. Ties keep the lower index.
  - If tmpl==N_TMPL-1 → DONE.
  - Otherwise tmpl++, row=0, acc=0, → SCAN.
- DONE:
  - `digit`←best_digit and `score`←best_score are registered on entry.
  - `done`=1 for exactly this cycle, then → IDLE.
- Address outputs:
  - `rom_addr` = `grid_addr` = row counter.
  - `tmpl_sel` = tmpl counter.
  - Both hold their values in CMP/DONE/IDLE and return to 0 on the next start.
- `digit`/`score` keep the previous run's result until the next DONE. They do not clear on `start`.
- `start` while busy is ignored; it is neither queued nor restarted.
- `rst` mid-run: the next state is IDLE. All outputs and counters take their reset values; no `done` is issued.
- Reset values: `tmpl_sel`=0, `rom_addr`=0, `grid_addr`=0, `busy`=0, `done`=0, `digit`=0, `score`=0. Internal acc, best_score and best_digit are 0.

## Timing
- Cycle 0: `start` sampled high in IDLE.
- Cycles 1..16: SCAN of template 0. Row r is presented during cycle 1+r.
- Cycle 17: CMP for template 0.
- Each template takes 17 cycles. CMP for template k is at cycle 17(k+1).
- Cycle 171 (N_TMPL=10): DONE, `done`=1, `digit`/`score` valid from this cycle onward.
- `busy`=1 during cycles 1..171; `busy`=0 at cycle 172.
- Earliest accepted restart: `start` sampled at cycle 172.
- ROM and grid reads are combinational within a cycle. No read latency is compensated.
- Score arithmetic is unsigned. Maximum is 256 (16×16 agreeing pixels), which needs all 9 bits.

## Test plan
- Grid loaded with the "1" bitmap; all ten real templates present → `done` at cycle 171, `digit`=1, `score`=256.
- Grid all ones; bench ROM model where template k has rows 0..k all ones and the other rows zero → `digit`=9, `score`=160.
- All templates identical, grid all zeros, all rows of every template zero → every score is 256; tie resolves to `digit`=0, `score`=256.
- `start` re-pulsed at cycle 50 during a run → a single `done` at cycle 171; `busy` falls at 172; no second run.
- `rst` asserted at cycle 80 → cycle 81 shows `busy`=0, `tmpl_sel`=0, `rom_addr`=0; no `done` pulse. A new `start` then completes at cycle 171 relative to it with the correct result.
- Back-to-back runs: second run with a different grid → `digit`/`score` hold the first result until the second `done`, then update.

Source files
------------

// File: rtl/digit_matcher.sv
// digit_matcher: scores a drawn 16x16 grid against N_TMPL bitmap templates by
// counting agreeing pixels row by row and reports the best-scoring template.
// Templates are scanned in index order; ties keep the lower index.
module digit_matcher #(
   parameter int N_TMPL = 10,
   parameter int ROWS   = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   output logic [3:0]  tmpl_sel,
   output logic [3:0]  rom_addr,
   input  logic [0:15] rom_row,
   output logic [3:0]  grid_addr,
   input  logic [0:15] grid_row,
   output logic        busy,
   output logic        done,
   output logic [3:0]  digit,
   output logic [8:0]  score
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SCAN = 2'd1,
      CMP  = 2'd2,
      DONE = 2'd3
   } state_t;

   localparam logic [3:0] LAST_ROW  = 4'(ROWS - 1);
   localparam logic [3:0] LAST_TMPL = 4'(N_TMPL - 1);

   state_t     state_reg, state_next;
   logic [3:0] tmpl_reg, tmpl_next;
   logic [3:0] row_reg, row_next;
   logic [8:0] acc_reg, acc_next;
   logic [8:0] best_score_reg, best_score_next;
   logic [3:0] best_digit_reg, best_digit_next;
   logic [3:0] digit_reg, digit_next;
   logic [8:0] score_reg, score_next;

   // ------------------------------------------------------------------
   // Per-row agreement count: XNOR each pixel pair, then a balanced adder
   // tree (16 -> 8 -> 4 -> 2 -> 1). Result range is 0..16.
   // ------------------------------------------------------------------
   logic [15:0] agree;
   logic [1:0]  sum_l1 [8];
   logic [2:0]  sum_l2 [4];
   logic [3:0]  sum_l3 [2];
   logic [4:0]  row_match;

   generate
      for (genvar gi = 0; gi < 16; gi++) begin : g_agree
         assign agree[gi] = ~(grid_row[gi] ^ rom_row[gi]);
      end
      for (genvar gi = 0; gi < 8; gi++) begin : g_l1
         assign sum_l1[gi] = {1'b0, agree[2*gi]} + {1'b0, agree[2*gi+1]};
      end
      for (genvar gi = 0; gi < 4; gi++) begin : g_l2
         assign sum_l2[gi] = {1'b0, sum_l1[2*gi]} + {1'b0, sum_l1[2*gi+1]};
      end
      for (genvar gi = 0; gi < 2; gi++) begin : g_l3
         assign sum_l3[gi] = {1'b0, sum_l2[2*gi]} + {1'b0, sum_l2[2*gi+1]};
      end
   endgenerate

   assign row_match = {1'b0, sum_l3[0]} + {1'b0, sum_l3[1]};

   // Strict comparison so an equal later score never displaces an earlier one.
   logic is_better;
   assign is_better = (acc_reg > best_score_reg);

   // Next-state and datapath update for the scan/compare sequence.
   always_comb begin
      state_next      = state_reg;
      tmpl_next       = tmpl_reg;
      row_next        = row_reg;
      acc_next        = acc_reg;
      best_score_next = best_score_reg;
      best_digit_next = best_digit_reg;
      digit_next      = digit_reg;
      score_next      = score_reg;

      case (state_reg)
         IDLE: begin
            if (start) begin
               state_next      = SCAN;
               tmpl_next       = 4'd0;
               row_next        = 4'd0;
               acc_next        = 9'd0;
               best_score_next = 9'd0;
               best_digit_next = 4'd0;
            end
         end

         SCAN: begin
            acc_next = acc_reg + 9'(row_match);
            // The address stays on the last row through CMP so the outputs
            // hold rather than wrap.
            if (row_reg == LAST_ROW) begin
               state_next = CMP;
            end else begin
               row_next = row_reg + 4'd1;
            end
         end

         CMP: begin
            if (is_better) begin
               best_score_next = acc_reg;
               best_digit_next = tmpl_reg;
            end
            if (tmpl_reg == LAST_TMPL) begin
               // Publish including this final comparison's outcome.
               state_next = DONE;
               digit_next = is_better ? tmpl_reg : best_digit_reg;
               score_next = is_better ? acc_reg  : best_score_reg;
            end else begin
               state_next = SCAN;
               tmpl_next  = tmpl_reg + 4'd1;
               row_next   = 4'd0;
               acc_next   = 9'd0;
            end
         end

         DONE: begin
            state_next = IDLE;
         end

         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // State and datapath registers; reset returns everything to zero.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg      <= IDLE;
         tmpl_reg       <= 4'd0;
         row_reg        <= 4'd0;
         acc_reg        <= 9'd0;
         best_score_reg <= 9'd0;
         best_digit_reg <= 4'd0;
         digit_reg      <= 4'd0;
         score_reg      <= 9'd0;
      end else begin
         state_reg      <= state_next;
         tmpl_reg       <= tmpl_next;
         row_reg        <= row_next;
         acc_reg        <= acc_next;
         best_score_reg <= best_score_next;
         best_digit_reg <= best_digit_next;
         digit_reg      <= digit_next;
         score_reg      <= score_next;
      end
   end

   assign tmpl_sel  = tmpl_reg;
   assign rom_addr  = row_reg;
   assign grid_addr = row_reg;
   assign busy      = (state_reg != IDLE);
   assign done      = (state_reg == DONE);
   assign digit     = digit_reg;
   assign score     = score_reg;

endmodule
